multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Main control FSM that sequences the shared-memory, single-ALU RISC-V (RV32I subset) multicycle datapath. One instruction takes 3–5 states.
- Decodes opcode/funct fields and the ALU zero flag. Drives all datapath mux selects and write enables.
- Stalls on a memory ready handshake. Sits beside the datapath inside the processor top.

Parameters:
- RESET_PC_WRITE, 0, value of pc_write while reset is asserted (kept parameterised for debug).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- opcode  input  7  instr[6:0] from instruction register
- funct3  input  3  instr[14:12]
- funct7b5  input  1  instr[30]
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory accepted write / has read data this cycle
- pc_write  output  1  PC register enable
- adr_src  output  1  memory address select: 0=PC, 1=ALUOut
- mem_write  output  1  memory write request
- ir_write  output  1  instruction register and OldPC enable
- result_src  output  2  00=ALUOut, 01=Data, 10=ALUResult
- alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
- alu_src_a  output  2  00=PC, 01=OldPC, 10=RegA, 11=zero
- alu_src_b  output  2  00=RegB, 01=Imm, 10=constant 4
- imm_src  output  3  000 I, 001 S, 010 B, 011 J, 100 U
- reg_write  output  1  register file write enable
- instr_retire  output  1  one-cycle pulse in the final state of each instruction
- illegal_op  output  1  one-cycle pulse in DECODE for an unsupported opcode

Behaviour:
- State register
  - Reset is asynchronous: reset low forces state=FETCH immediately, mid-instruction included.
  - While reset is low, pc_write=RESET_PC_WRITE and ir_write, mem_write, reg_write, instr_retire, illegal_op are all 0. Select outputs hold their FETCH values.
- Outputs are Moore outputs decoded from state. Exceptions:
  - pc_write in BRANCH depends on zero/funct3.
  - alu_control in EXECR/EXECI is decoded from the funct fields.
  - Handshake-gated enables, as listed per state.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=01, alu_src_b=01, imm_src=B, add (branch target into ALUOut).
  - Transitions by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 0110111 -> LUI
    - other -> FETCH with illegal_op=1, no retire.
- MEMADR: alu_src_a=10, alu_src_b=01, add. imm_src=S if opcode[5]=1, else I.
  - Goes to MEMREAD if opcode[5]=0, else MEMWRITE.
- MEMREAD: adr_src=1. Waits for mem_ready, then -> MEMWB.
- MEMWB: result_src=01, reg_write=1, retire, -> FETCH.
- MEMWRITE: adr_src=1, mem_write=1 held until mem_ready=1. On the mem_ready=1 cycle: retire, -> FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, funct decode, -> ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, imm_src=I, funct decode, -> ALUWB.
- Funct decode (funct3 -> alu_control):
  - 000 -> add, or sub when opcode[5]&funct7b5.
  - 001 -> sll
  - 010 -> slt
  - 100 -> xor
  - 101 -> srl (funct7b5 ignored; sra unsupported)
  - 110 -> or
  - 111 -> and
  - 011 -> slt
- ALUWB: result_src=00, reg_write=1, retire, -> FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, sub, result_src=00, retire, -> FETCH.
  - pc_write = zero when funct3=000, !zero when funct3=001, 0 otherwise.
- JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1, -> ALUWB.
- LUI: alu_src_a=11, alu_src_b=01, imm_src=U, add, -> ALUWB.
- Latency with mem_ready always 1:
  - R/I/LUI: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq/bne: 3 cycles
  - jal: 4 cycles
- Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- Unused output fields are driven 0; no X on any output.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum (4-bit): FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, LUI
  - opcode constants
  - alu_control, imm_src, result_src and alu_src encodings
- Sub-module alu_decoder (combinational: opcode[5], funct3, funct7b5, alu_op -> alu_control) is split out. The FSM supplies alu_op (00 add, 01 sub, 10 funct).

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release.
  - During reset all enables are 0 and state=FETCH.
  - First post-reset cycle: ir_write=pc_write=1 with mem_ready=1.
- add x3,x1,x2 (0x002081B3), mem_ready=1:
  - 4 cycles; EXECR alu_control=000.
  - ALUWB reg_write=1, instr_retire=1.
  - Same test with sub (0x402081B3) gives alu_control=001.
- lw (0x0000A183) with mem_ready low for 2 cycles in MEMREAD:
  - 7 cycles total; adr_src=1 throughout MEMREAD.
  - MEMWB result_src=01.
  - Drop reset mid-MEMREAD once: immediate return to FETCH, no reg_write.
- sw (0x0020A023): mem_write stays 1 while mem_ready=0 for 3 cycles, deasserts after the ready cycle, retire once.
- beq (0x00208463):
  - zero=1 -> pc_write=1 in BRANCH.
  - zero=0 -> pc_write=0.
  - bne (funct3=001) inverts both.
  - 3 cycles each.
- jal (0x008000EF) -> JAL pc_write=1, then ALUWB reg_write=1. lui (0x000012B7) -> alu_src_a=11, imm_src=100. Opcode 0x7F -> illegal_op pulse, back to FETCH, no retire.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle control path: FSM states,
// opcodes and the mux-select / ALU encodings the datapath expects.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      JAL      = 4'd10,
      LUI      = 4'd11
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [2:0] ALU_SLL = 3'b110;
   localparam logic [2:0] ALU_SRL = 3'b111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_REGA  = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_REGB = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   function automatic logic is_supported(input logic [6:0] op);
      return (op == OP_LOAD)   || (op == OP_STORE) || (op == OP_RTYPE) ||
             (op == OP_ITYPE)  || (op == OP_BRANCH) || (op == OP_JAL)  ||
             (op == OP_LUI);
   endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU control decode from the FSM's alu_op request and the
// instruction funct fields.
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic       opcode_b5_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   input  logic [1:0] alu_op_i,
   output logic [2:0] alu_control_o
);

   // ALU operation select
   always_comb begin
      alu_control_o = ALU_ADD;
      case (alu_op_i)
         ALUOP_ADD: alu_control_o = ALU_ADD;
         ALUOP_SUB: alu_control_o = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3_i)
               3'b000:  alu_control_o = (opcode_b5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_control_o = ALU_SLL;
               3'b010:  alu_control_o = ALU_SLT;
               3'b011:  alu_control_o = ALU_SLT;
               3'b100:  alu_control_o = ALU_XOR;
               3'b101:  alu_control_o = ALU_SRL; // sra not supported, funct7b5 ignored
               3'b110:  alu_control_o = ALU_OR;
               3'b111:  alu_control_o = ALU_AND;
               default: alu_control_o = ALU_ADD;
            endcase
         end
         default: alu_control_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the shared-memory, single-ALU RV32I multicycle
// datapath: drives all mux selects and enables, stalls on mem_ready.
module multicycle_controller
   import riscv_ctrl_pkg::*;
#(
   parameter logic RESET_PC_WRITE = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] result_src,
   output logic [2:0] alu_control,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] imm_src,
   output logic       reg_write,
   output logic       instr_retire,
   output logic       illegal_op
);

   state_t     state_q, state_d;
   logic       pc_write_s, adr_src_s, mem_write_s, ir_write_s;
   logic       reg_write_s, retire_s, illegal_s;
   logic [1:0] result_src_s, alu_src_a_s, alu_src_b_s, alu_op_s;
   logic [2:0] imm_src_s;

   // State register; reset returns to FETCH immediately, even mid-instruction
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and Moore outputs, with the few input-dependent exceptions
   always_comb begin
      state_d      = state_q;
      pc_write_s   = 1'b0;
      adr_src_s    = 1'b0;
      mem_write_s  = 1'b0;
      ir_write_s   = 1'b0;
      reg_write_s  = 1'b0;
      retire_s     = 1'b0;
      illegal_s    = 1'b0;
      result_src_s = RES_ALUOUT;
      alu_src_a_s  = SRCA_PC;
      alu_src_b_s  = SRCB_REGB;
      alu_op_s     = ALUOP_ADD;
      imm_src_s    = IMM_I;
      case (state_q)
         FETCH: begin
            alu_src_b_s  = SRCB_FOUR;
            result_src_s = RES_ALURESULT;
            ir_write_s   = mem_ready;
            pc_write_s   = mem_ready;
            state_d      = mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            // Branch target is precomputed into ALUOut here
            alu_src_a_s = SRCA_OLDPC;
            alu_src_b_s = SRCB_IMM;
            imm_src_s   = IMM_B;
            illegal_s   = !is_supported(opcode);
            case (opcode)
               OP_LOAD:   state_d = MEMADR;
               OP_STORE:  state_d = MEMADR;
               OP_RTYPE:  state_d = EXECR;
               OP_ITYPE:  state_d = EXECI;
               OP_BRANCH: state_d = BRANCH;
               OP_JAL:    state_d = JAL;
               OP_LUI:    state_d = LUI;
               default:   state_d = FETCH;
            endcase
         end
         MEMADR: begin
            alu_src_a_s = SRCA_REGA;
            alu_src_b_s = SRCB_IMM;
            imm_src_s   = opcode[5] ? IMM_S : IMM_I;
            state_d     = opcode[5] ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            adr_src_s = 1'b1;
            state_d   = mem_ready ? MEMWB : MEMREAD;
         end
         MEMWB: begin
            result_src_s = RES_DATA;
            reg_write_s  = 1'b1;
            retire_s     = 1'b1;
            state_d      = FETCH;
         end
         MEMWRITE: begin
            adr_src_s   = 1'b1;
            mem_write_s = 1'b1;
            retire_s    = mem_ready;
            state_d     = mem_ready ? FETCH : MEMWRITE;
         end
         EXECR: begin
            alu_src_a_s = SRCA_REGA;
            alu_op_s    = ALUOP_FUNCT;
            state_d     = ALUWB;
         end
         EXECI: begin
            alu_src_a_s = SRCA_REGA;
            alu_src_b_s = SRCB_IMM;
            alu_op_s    = ALUOP_FUNCT;
            state_d     = ALUWB;
         end
         ALUWB: begin
            reg_write_s = 1'b1;
            retire_s    = 1'b1;
            state_d     = FETCH;
         end
         BRANCH: begin
            alu_src_a_s = SRCA_REGA;
            alu_op_s    = ALUOP_SUB;
            retire_s    = 1'b1;
            state_d     = FETCH;
            case (funct3)
               3'b000:  pc_write_s = zero;
               3'b001:  pc_write_s = !zero;
               default: pc_write_s = 1'b0;
            endcase
         end
         JAL: begin
            alu_src_a_s = SRCA_OLDPC;
            alu_src_b_s = SRCB_FOUR;
            pc_write_s  = 1'b1;
            state_d     = ALUWB;
         end
         LUI: begin
            alu_src_a_s = SRCA_ZERO;
            alu_src_b_s = SRCB_IMM;
            imm_src_s   = IMM_U;
            state_d     = ALUWB;
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   alu_decoder u_alu_decoder (
      .opcode_b5_i   (opcode[5]),
      .funct3_i      (funct3),
      .funct7b5_i    (funct7b5),
      .alu_op_i      (alu_op_s),
      .alu_control_o (alu_control)
   );

   // Enables are forced off combinationally so reset takes effect at once
   assign pc_write     = reset ? pc_write_s : RESET_PC_WRITE;
   assign ir_write     = reset & ir_write_s;
   assign mem_write    = reset & mem_write_s;
   assign reg_write    = reset & reg_write_s;
   assign instr_retire = reset & retire_s;
   assign illegal_op   = reset & illegal_s;
   assign adr_src      = adr_src_s;
   assign result_src   = result_src_s;
   assign alu_src_a    = alu_src_a_s;
   assign alu_src_b    = alu_src_b_s;
   assign imm_src      = imm_src_s;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: directed and random instructions compared per cycle
// against a phase-sequence reference built from the instruction class.
module tb_multicycle_controller;

   typedef enum {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_XR, P_XI, P_AWB, P_BR, P_J, P_L} ph_t;

   localparam logic TB_RESET_PC_WRITE = 1'b0;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [6:0] opcode = 7'd0;
   logic [2:0] funct3 = 3'd0;
   logic       funct7b5 = 1'b0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b1;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write, instr_retire, illegal_op;
   logic [1:0] result_src, alu_src_a, alu_src_b;
   logic [2:0] alu_control, imm_src;
   logic [18:0] obs;

   int errors = 0;
   int checks = 0;

   multicycle_controller #(.RESET_PC_WRITE(TB_RESET_PC_WRITE)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
      .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
      .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .imm_src(imm_src), .reg_write(reg_write), .instr_retire(instr_retire),
      .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   assign obs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_control,
                 alu_src_a, alu_src_b, imm_src, reg_write, instr_retire, illegal_op};

   function automatic logic legal(input logic [6:0] op);
      return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                        7'b1100011, 7'b1101111, 7'b0110111};
   endfunction

   function automatic logic [2:0] alu_fn(input logic op5, input logic [2:0] f3, input logic f7);
      case (f3)
         3'b000:  return (op5 && f7) ? 3'b001 : 3'b000;
         3'b001:  return 3'b110;
         3'b010:  return 3'b101;
         3'b011:  return 3'b101;
         3'b100:  return 3'b100;
         3'b101:  return 3'b111;
         3'b110:  return 3'b011;
         default: return 3'b010;
      endcase
   endfunction

   // Expected output vector for one cycle of a given instruction phase
   function automatic logic [18:0] exp_out(input ph_t ph, input logic rdy, input logic [6:0] op,
                                           input logic [2:0] f3, input logic f7, input logic z);
      logic pcw = 1'b0, adr = 1'b0, mw = 1'b0, irw = 1'b0, rw = 1'b0, ret = 1'b0, ill = 1'b0;
      logic [1:0] rs = 2'b00, sa = 2'b00, sb = 2'b00;
      logic [2:0] ac = 3'b000, is = 3'b000;
      case (ph)
         P_F:   begin sb = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
         P_D:   begin sa = 2'b01; sb = 2'b01; is = 3'b010; ill = !legal(op); end
         P_MA:  begin sa = 2'b10; sb = 2'b01; is = op[5] ? 3'b001 : 3'b000; end
         P_MR:  begin adr = 1'b1; end
         P_MWB: begin rs = 2'b01; rw = 1'b1; ret = 1'b1; end
         P_MW:  begin adr = 1'b1; mw = 1'b1; ret = rdy; end
         P_XR:  begin sa = 2'b10; ac = alu_fn(op[5], f3, f7); end
         P_XI:  begin sa = 2'b10; sb = 2'b01; ac = alu_fn(op[5], f3, f7); end
         P_AWB: begin rw = 1'b1; ret = 1'b1; end
         P_BR:  begin
            sa = 2'b10; ac = 3'b001; ret = 1'b1;
            pcw = (f3 == 3'b000) ? z : ((f3 == 3'b001) ? !z : 1'b0);
         end
         P_J:   begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
         P_L:   begin sa = 2'b11; sb = 2'b01; is = 3'b100; end
         default: ;
      endcase
      return {pcw, adr, mw, irw, rs, ac, sa, sb, is, rw, ret, ill};
   endfunction

   function automatic logic [18:0] exp_reset();
      logic [18:0] v;
      v = exp_out(P_F, 1'b1, 7'd0, 3'd0, 1'b0, 1'b0);
      v[18] = TB_RESET_PC_WRITE;
      v[15] = 1'b0;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   // Runs one instruction, stalling fetch_st cycles in FETCH and mem_st in the memory phase
   task automatic run_instr(input string tag, input logic [31:0] ins, input logic z,
                            input int fetch_st, input int mem_st);
      ph_t q[$];
      int  idx = 0;
      int  fs = fetch_st;
      int  ms = mem_st;
      int  rets = 0;
      int  ills = 0;
      logic rdy;
      logic [6:0] op = ins[6:0];
      q.push_back(P_F);
      q.push_back(P_D);
      case (op)
         7'b0000011: begin q.push_back(P_MA); q.push_back(P_MR); q.push_back(P_MWB); end
         7'b0100011: begin q.push_back(P_MA); q.push_back(P_MW); end
         7'b0110011: begin q.push_back(P_XR); q.push_back(P_AWB); end
         7'b0010011: begin q.push_back(P_XI); q.push_back(P_AWB); end
         7'b1100011: q.push_back(P_BR);
         7'b1101111: begin q.push_back(P_J); q.push_back(P_AWB); end
         7'b0110111: begin q.push_back(P_L); q.push_back(P_AWB); end
         default: ;
      endcase
      while (idx < q.size()) begin
         @(negedge clk);
         if (idx == 0 && fs == fetch_st) begin
            reset    = 1'b1;
            opcode   = op;
            funct3   = ins[14:12];
            funct7b5 = ins[30];
            zero     = z;
         end
         if (q[idx] == P_F) rdy = (fs == 0);
         else if (q[idx] == P_MR || q[idx] == P_MW) rdy = (ms == 0);
         else rdy = 1'($urandom_range(0, 1));
         mem_ready = rdy;
         #1;
         chk(tag, 32'(obs), 32'(exp_out(q[idx], rdy, op, ins[14:12], ins[30], z)));
         if (instr_retire === 1'b1) rets++;
         if (illegal_op === 1'b1) ills++;
         if (q[idx] == P_F && !rdy) fs--;
         else if ((q[idx] == P_MR || q[idx] == P_MW) && !rdy) ms--;
         else idx++;
      end
      chk({tag, "_retires"}, 32'(rets), legal(op) ? 32'd1 : 32'd0);
      chk({tag, "_illegal"}, 32'(ills), legal(op) ? 32'd0 : 32'd1);
   endtask

   logic [6:0] pool [10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                             7'b1101111, 7'b0110111, 7'b1111111, 7'b0010111, 7'b1100111};

   initial begin
      // Reset held for three cycles with mem_ready high
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         mem_ready = 1'b1;
         #1;
         chk("reset_hold", 32'(obs), 32'(exp_reset()));
      end

      run_instr("add",  32'h002081B3, 1'b0, 0, 0);
      run_instr("sub",  32'h402081B3, 1'b0, 0, 0);
      run_instr("lw",   32'h0000A183, 1'b0, 0, 2);
      run_instr("sw",   32'h0020A023, 1'b0, 0, 3);
      run_instr("beq1", 32'h00208463, 1'b1, 0, 0);
      run_instr("beq0", 32'h00208463, 1'b0, 0, 0);
      run_instr("bne1", 32'h00209463, 1'b1, 0, 0);
      run_instr("bne0", 32'h00209463, 1'b0, 0, 0);
      run_instr("blt",  32'h0020C463, 1'b1, 0, 0);
      run_instr("jal",  32'h008000EF, 1'b0, 0, 0);
      run_instr("lui",  32'h000012B7, 1'b0, 0, 0);
      run_instr("ill",  32'h0000007F, 1'b0, 0, 0);
      run_instr("fstall", 32'h00108093, 1'b0, 2, 0);

      // Reset dropped while stalled in MEMREAD
      @(negedge clk);
      opcode = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; mem_ready = 1'b1;
      #1 chk("rst_mid_f", 32'(obs), 32'(exp_out(P_F, 1'b1, 7'b0000011, 3'b010, 1'b0, 1'b0)));
      @(negedge clk);
      #1 chk("rst_mid_d", 32'(obs), 32'(exp_out(P_D, 1'b1, 7'b0000011, 3'b010, 1'b0, 1'b0)));
      @(negedge clk);
      #1 chk("rst_mid_ma", 32'(obs), 32'(exp_out(P_MA, 1'b1, 7'b0000011, 3'b010, 1'b0, 1'b0)));
      @(negedge clk);
      mem_ready = 1'b0;
      #1 chk("rst_mid_mr", 32'(obs), 32'(exp_out(P_MR, 1'b0, 7'b0000011, 3'b010, 1'b0, 1'b0)));
      #2 reset = 1'b0;
      #1 chk("rst_mid_async", 32'(obs), 32'(exp_reset()));
      @(negedge clk);
      mem_ready = 1'b1;
      #1 chk("rst_mid_hold", 32'(obs), 32'(exp_reset()));
      run_instr("post_rst_add", 32'h002081B3, 1'b0, 0, 0);

      // Random instruction stream with random stalls
      for (int n = 0; n < 80; n++) begin
         logic [31:0] ins;
         ins = $urandom;
         ins[6:0] = pool[$urandom_range(0, 9)];
         run_instr("rand", ins, 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
